// File: rtl/pp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pp_pkg
//  Description : Shared defaults, width helpers and tracker state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package pp_pkg;

    localparam int C_IMG_W_DEFAULT     = 640;
    localparam int C_IMG_H_DEFAULT     = 480;
    localparam int C_MIN_COUNT_DEFAULT = 16;

    // Bits needed to index n values; never narrower than one bit.
    function automatic int pp_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [0:0] {
        ST_WAIT_SOF = 1'b0,
        ST_ACCUM    = 1'b1
    } pp_state_t;

endpackage
`default_nettype wire

// File: rtl/pp_pix_position.sv
`default_nettype none
// ============================================================================
//  Module      : pp_pix_position
//  Description : Pixel x/y tracking with start-of-frame / end-of-line errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module pp_pix_position
    import pp_pkg::*;
#(
    parameter  int IMG_W = C_IMG_W_DEFAULT,
    parameter  int IMG_H = C_IMG_H_DEFAULT,
    localparam int XW    = pp_width(IMG_W),
    localparam int YW    = pp_width(IMG_H)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_beat,
    input  logic          i_in_frame,
    input  logic          i_tuser,
    input  logic          i_tlast,
    output logic [XW-1:0] o_x,
    output logic [YW-1:0] o_y,
    output logic [XW-1:0] o_px,
    output logic [YW-1:0] o_py,
    output logic          o_pix,
    output logic          o_start,
    output logic          o_frame_end,
    output logic          o_err_sof,
    output logic          o_err_eol
);

    localparam logic [XW-1:0] C_X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] C_Y_LAST = YW'(IMG_H - 1);

    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic          r_err_sof;
    logic          r_err_eol;
    logic          w_sof_err;
    logic          w_eol_err;

    // A tuser beat is always pixel (0,0), whatever the counters say.
    always_comb begin
        o_start     = i_beat && i_tuser;
        o_pix       = i_beat && (i_in_frame || i_tuser);
        o_px        = o_start ? '0 : r_x;
        o_py        = o_start ? '0 : r_y;
        o_frame_end = o_pix && i_tlast && (o_py == C_Y_LAST);
        w_sof_err   = o_start && i_in_frame && ((r_x != '0) || (r_y != '0));
        w_eol_err   = o_pix && i_tlast && (o_px != C_X_LAST);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_x       <= '0;
            r_y       <= '0;
            r_err_sof <= 1'b0;
            r_err_eol <= 1'b0;
        end else begin
            if (o_pix) begin
                if (o_frame_end) begin
                    r_x <= '0;
                    r_y <= '0;
                end else if (i_tlast) begin
                    r_x <= '0;
                    r_y <= o_py + YW'(1);
                end else begin
                    // Overlong lines pin at the last column instead of wrapping.
                    r_x <= (o_px == C_X_LAST) ? o_px : o_px + XW'(1);
                    r_y <= o_py;
                end
            end
            if (w_sof_err) r_err_sof <= 1'b1;
            if (w_eol_err) r_err_eol <= 1'b1;
        end
    end

    assign o_x       = r_x;
    assign o_y       = r_y;
    assign o_err_sof = r_err_sof;
    assign o_err_eol = r_err_eol;

endmodule
`default_nettype wire

// File: rtl/pp_red_bbox_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : pp_red_bbox_tracker
//  Description : Per-frame bounding box and count of red pixels in a mask stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module pp_red_bbox_tracker
    import pp_pkg::*;
#(
    parameter  int IMG_W     = C_IMG_W_DEFAULT,
    parameter  int IMG_H     = C_IMG_H_DEFAULT,
    parameter  int MIN_COUNT = C_MIN_COUNT_DEFAULT,
    localparam int XW        = pp_width(IMG_W),
    localparam int YW        = pp_width(IMG_H),
    localparam int CW        = pp_width(IMG_W * IMG_H + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_tvalid,
    input  logic          i_tdata,
    input  logic          i_tuser,
    input  logic          i_tlast,
    output logic          o_tready,
    output logic          o_bbox_valid,
    input  logic          i_bbox_ready,
    output logic          o_found,
    output logic [XW-1:0] o_xmin,
    output logic [XW-1:0] o_xmax,
    output logic [YW-1:0] o_ymin,
    output logic [YW-1:0] o_ymax,
    output logic [CW-1:0] o_count,
    output logic          o_err_sof,
    output logic          o_err_eol
);

    localparam logic [XW-1:0] C_X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] C_Y_LAST = YW'(IMG_H - 1);
    localparam logic [CW-1:0] C_MIN    = CW'(MIN_COUNT);

    pp_state_t     r_state;
    pp_state_t     w_state_nxt;

    logic          w_beat;
    logic [XW-1:0] w_x;
    logic [YW-1:0] w_y;
    logic [XW-1:0] w_px;
    logic [YW-1:0] w_py;
    logic          w_pix;
    logic          w_start;
    logic          w_frame_end;
    logic          w_load;

    logic [XW-1:0] r_xmin, r_xmax, w_xmin_base, w_xmax_base, w_xmin_upd, w_xmax_upd;
    logic [YW-1:0] r_ymin, r_ymax, w_ymin_base, w_ymax_base, w_ymin_upd, w_ymax_upd;
    logic [CW-1:0] r_cnt, w_cnt_base, w_cnt_upd;
    logic          w_found_upd;

    logic          r_bbox_valid;
    logic          r_found;
    logic [XW-1:0] r_res_xmin, r_res_xmax;
    logic [YW-1:0] r_res_ymin, r_res_ymax;
    logic [CW-1:0] r_res_count;

    // Stall only the frame-end beat while an unread result is still pending.
    assign o_tready = !((w_x == C_X_LAST) && (w_y == C_Y_LAST) && r_bbox_valid && !i_bbox_ready);
    assign w_beat   = i_tvalid && o_tready;

    pp_pix_position #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H)
    ) u_pos (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_beat      (w_beat),
        .i_in_frame  (r_state == ST_ACCUM),
        .i_tuser     (i_tuser),
        .i_tlast     (i_tlast),
        .o_x         (w_x),
        .o_y         (w_y),
        .o_px        (w_px),
        .o_py        (w_py),
        .o_pix       (w_pix),
        .o_start     (w_start),
        .o_frame_end (w_frame_end),
        .o_err_sof   (o_err_sof),
        .o_err_eol   (o_err_eol)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= ST_WAIT_SOF;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_WAIT_SOF: if (w_start && !w_frame_end) w_state_nxt = ST_ACCUM;
            ST_ACCUM:    if (w_frame_end)             w_state_nxt = ST_WAIT_SOF;
            default:                                  w_state_nxt = ST_WAIT_SOF;
        endcase
    end

    // A tuser beat starts from cleared accumulators, dropping any partial frame.
    always_comb begin
        w_xmin_base = w_start ? '1 : r_xmin;
        w_xmax_base = w_start ? '0 : r_xmax;
        w_ymin_base = w_start ? '1 : r_ymin;
        w_ymax_base = w_start ? '0 : r_ymax;
        w_cnt_base  = w_start ? '0 : r_cnt;
        w_xmin_upd  = w_xmin_base;
        w_xmax_upd  = w_xmax_base;
        w_ymin_upd  = w_ymin_base;
        w_ymax_upd  = w_ymax_base;
        w_cnt_upd   = w_cnt_base;
        if (i_tdata) begin
            if (w_px < w_xmin_base) w_xmin_upd = w_px;
            if (w_px > w_xmax_base) w_xmax_upd = w_px;
            if (w_py < w_ymin_base) w_ymin_upd = w_py;
            if (w_py > w_ymax_base) w_ymax_upd = w_py;
            if (w_cnt_base != '1)   w_cnt_upd  = w_cnt_base + CW'(1);
        end
        w_found_upd = (w_cnt_upd >= C_MIN);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_xmin <= '1;
            r_xmax <= '0;
            r_ymin <= '1;
            r_ymax <= '0;
            r_cnt  <= '0;
        end else if (w_frame_end) begin
            r_xmin <= '1;
            r_xmax <= '0;
            r_ymin <= '1;
            r_ymax <= '0;
            r_cnt  <= '0;
        end else if (w_pix) begin
            r_xmin <= w_xmin_upd;
            r_xmax <= w_xmax_upd;
            r_ymin <= w_ymin_upd;
            r_ymax <= w_ymax_upd;
            r_cnt  <= w_cnt_upd;
        end
    end

    // A malformed frame ending early while a result is unread is dropped,
    // so a pending result never changes under the consumer.
    assign w_load = w_frame_end && (!r_bbox_valid || i_bbox_ready);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_bbox_valid <= 1'b0;
            r_found      <= 1'b0;
            r_res_xmin   <= '0;
            r_res_xmax   <= '0;
            r_res_ymin   <= '0;
            r_res_ymax   <= '0;
            r_res_count  <= '0;
        end else if (w_load) begin
            r_bbox_valid <= 1'b1;
            r_found      <= w_found_upd;
            r_res_xmin   <= w_found_upd ? w_xmin_upd : '0;
            r_res_xmax   <= w_found_upd ? w_xmax_upd : '0;
            r_res_ymin   <= w_found_upd ? w_ymin_upd : '0;
            r_res_ymax   <= w_found_upd ? w_ymax_upd : '0;
            r_res_count  <= w_cnt_upd;
        end else if (r_bbox_valid && i_bbox_ready) begin
            r_bbox_valid <= 1'b0;
        end
    end

    assign o_bbox_valid = r_bbox_valid;
    assign o_found      = r_found;
    assign o_xmin       = r_res_xmin;
    assign o_xmax       = r_res_xmax;
    assign o_ymin       = r_res_ymin;
    assign o_ymax       = r_res_ymax;
    assign o_count      = r_res_count;

endmodule
`default_nettype wire

// File: tb/tb_pp_red_bbox_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pp_red_bbox_tracker
//  Description : Directed self-checking bench for pp_red_bbox_tracker (8x4, min 2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pp_red_bbox_tracker;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_tvalid = 1'b0;
    logic       i_tdata = 1'b0;
    logic       i_tuser = 1'b0;
    logic       i_tlast = 1'b0;
    logic       i_bbox_ready = 1'b1;
    logic       o_tready;
    logic       o_bbox_valid;
    logic       o_found;
    logic [2:0] o_xmin, o_xmax;
    logic [1:0] o_ymin, o_ymax;
    logic [5:0] o_count;
    logic       o_err_sof;
    logic       o_err_eol;

    int checks = 0;
    int failures = 0;

    pp_red_bbox_tracker #(
        .IMG_W     (8),
        .IMG_H     (4),
        .MIN_COUNT (2)
    ) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_tvalid     (i_tvalid),
        .i_tdata      (i_tdata),
        .i_tuser      (i_tuser),
        .i_tlast      (i_tlast),
        .o_tready     (o_tready),
        .o_bbox_valid (o_bbox_valid),
        .i_bbox_ready (i_bbox_ready),
        .o_found      (o_found),
        .o_xmin       (o_xmin),
        .o_xmax       (o_xmax),
        .o_ymin       (o_ymin),
        .o_ymax       (o_ymax),
        .o_count      (o_count),
        .o_err_sof    (o_err_sof),
        .o_err_eol    (o_err_eol)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the beat was accepted.
    task automatic drive(input logic d, input logic u, input logic l);
        int n;
        i_tvalid = 1'b1;
        i_tdata  = d;
        i_tuser  = u;
        i_tlast  = l;
        n = 0;
        while (!o_tready && n < 50) begin
            @(negedge i_clk);
            n++;
        end
        if (n >= 50) begin
            failures++;
            $display("FAIL tready_timeout got=0 exp=1");
        end
        @(negedge i_clk);
    endtask

    task automatic idle();
        i_tvalid = 1'b0;
        i_tdata  = 1'b0;
        i_tuser  = 1'b0;
        i_tlast  = 1'b0;
    endtask

    task automatic send_px(input int x, input int y, input logic [31:0] m);
        drive(m[y*8+x], (x == 0) && (y == 0), x == 7);
    endtask

    task automatic send_frame(input logic [31:0] m);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 8; x++)
                send_px(x, y, m);
        idle();
    endtask

    task automatic chk_res(input string tag, input logic f, input int xmn, input int xmx,
                           input int ymn, input int ymx, input int cnt);
        chk({tag, "_valid"}, o_bbox_valid, 1);
        chk({tag, "_found"}, o_found, f);
        chk({tag, "_xmin"},  o_xmin, xmn);
        chk({tag, "_xmax"},  o_xmax, xmx);
        chk({tag, "_ymin"},  o_ymin, ymn);
        chk({tag, "_ymax"},  o_ymax, ymx);
        chk({tag, "_count"}, o_count, cnt);
    endtask

    initial begin
        logic [31:0] m;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);

        // Reset state
        chk("rst_tready",  o_tready, 1);
        chk("rst_valid",   o_bbox_valid, 0);
        chk("rst_found",   o_found, 0);
        chk("rst_count",   o_count, 0);
        chk("rst_err_sof", o_err_sof, 0);
        chk("rst_err_eol", o_err_eol, 0);

        // Red at (2,1) and (5,3)
        m = 32'h0;
        m[10] = 1'b1;
        m[29] = 1'b1;
        send_frame(m);
        chk_res("frameA", 1'b1, 2, 5, 1, 3, 2);
        @(negedge i_clk);
        chk("frameA_hs_clear", o_bbox_valid, 0);

        // Single red at (7,3): below MIN_COUNT
        m = 32'h0;
        m[31] = 1'b1;
        send_frame(m);
        chk_res("frameB", 1'b0, 0, 0, 0, 0, 1);
        @(negedge i_clk);

        // Backpressure: frame C result held across frame D's last beat
        i_bbox_ready = 1'b0;
        m = 32'h0;
        m[0]  = 1'b1;
        m[19] = 1'b1;
        send_frame(m);
        chk_res("frameC", 1'b1, 0, 3, 0, 2, 2);
        m = 32'h0;
        m[9]  = 1'b1;
        m[22] = 1'b1;
        m[31] = 1'b1;
        for (int i = 0; i < 31; i++) send_px(i % 8, i / 8, m);
        i_tvalid = 1'b1;
        i_tdata  = 1'b1;
        i_tuser  = 1'b0;
        i_tlast  = 1'b1;
        chk("bp_tready_low", o_tready, 0);
        @(negedge i_clk);
        chk("bp_tready_still_low", o_tready, 0);
        chk_res("bp_hold", 1'b1, 0, 3, 0, 2, 2);
        i_bbox_ready = 1'b1;
        #1;
        chk("bp_tready_release", o_tready, 1);
        @(negedge i_clk);
        idle();
        chk_res("frameD", 1'b1, 1, 7, 1, 3, 3);
        @(negedge i_clk);
        chk("frameD_hs_clear", o_bbox_valid, 0);

        // Garbage before tuser, then restart mid-frame at row 2
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        idle();
        @(negedge i_clk);
        chk("garbage_no_result", o_bbox_valid, 0);
        chk("garbage_no_eol",    o_err_eol, 0);
        chk("garbage_no_sof",    o_err_sof, 0);
        m = 32'h0;
        m[7] = 1'b1;
        m[8] = 1'b1;
        for (int i = 0; i < 16; i++) send_px(i % 8, i / 8, m);
        m = 32'h0;
        m[1]  = 1'b1;
        m[22] = 1'b1;
        send_frame(m);
        chk("restart_err_sof", o_err_sof, 1);
        chk_res("restart", 1'b1, 1, 6, 0, 2, 2);
        @(negedge i_clk);

        // Short first line: tlast at x=5
        m = 32'h0;
        m[2]  = 1'b1;
        m[22] = 1'b1;
        for (int x = 0; x < 6; x++) drive(m[x], x == 0, x == 5);
        for (int y = 1; y < 4; y++)
            for (int x = 0; x < 8; x++)
                send_px(x, y, m);
        idle();
        chk("eol_err", o_err_eol, 1);
        chk_res("eol_frame", 1'b1, 2, 6, 0, 2, 2);
        @(negedge i_clk);
        chk("eol_sticky", o_err_eol, 1);

        // Reset mid-frame
        m = 32'hFFFF_FFFF;
        for (int i = 0; i < 10; i++) send_px(i % 8, i / 8, m);
        idle();
        i_rst = 1'b1;
        #1;
        chk("midrst_valid",   o_bbox_valid, 0);
        chk("midrst_count",   o_count, 0);
        chk("midrst_xmax",    o_xmax, 0);
        chk("midrst_err_sof", o_err_sof, 0);
        chk("midrst_err_eol", o_err_eol, 0);
        chk("midrst_tready",  o_tready, 1);
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (4) @(negedge i_clk);
        chk("midrst_no_result", o_bbox_valid, 0);
        m = 32'h0;
        m[12] = 1'b1;
        m[26] = 1'b1;
        send_frame(m);
        chk_res("post_rst", 1'b1, 2, 4, 1, 3, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=0 exp=1");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
